irq_controller: RTL



---
 rtl/irq_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// irq_controller: vectored interrupt controller between interrupt sources and
// the CPU's PC-select logic. Rising edges on irq_in are latched as pending.
// Pending sources that are also enabled are resolved by fixed priority, where
// the lowest index wins. The winner is offered as a request plus a vector
// address, using a req/ack/done handshake.
// Optional build macro IRQ_NEST_EN turns on nesting. With nesting on, a
// strictly higher-priority candidate preempts an active service routine.
module irq_controller #(
  parameter int          NUM_IRQ  = 4,
  parameter int          ADDR_W   = 10,
  parameter int unsigned VEC_BASE = 32'h3FA,
  parameter int          ID_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               en_we,
  input  logic [NUM_IRQ-1:0] en_wdata,
  input  logic               ack,
  input  logic               done,
  output logic               irq_req,
  output logic [ADDR_W-1:0]  dir_out,
  output logic [ID_W-1:0]    irq_id,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t               state_reg, state_next;
  logic [NUM_IRQ-1:0]   irq_prev_reg;
  logic [NUM_IRQ-1:0]   pending_reg, pending_next;
  logic [NUM_IRQ-1:0]   enable_reg, enable_next;
  logic [NUM_IRQ-1:0]   isv_reg, isv_next;
  logic                 req_reg, req_next;
  logic [ADDR_W-1:0]    dir_reg, dir_next;
  logic [ID_W-1:0]      id_reg, id_next;

  logic [NUM_IRQ-1:0]   rise, cand, pend_clr, isv_set, isv_clr, id_hot;
  logic [ID_W-1:0]      win_id;

  // The last vector must be addressable; a bad parameter set fails elaboration.
  generate
    if ((64'(VEC_BASE) + 64'(NUM_IRQ) - 64'd1) > ((64'd1 << ADDR_W) - 64'd1)) begin : g_vec_check
      $error("irq_controller: VEC_BASE+NUM_IRQ-1 does not fit in ADDR_W bits");
    end
  endgenerate

  // A source raises an event on a rising edge seen against its previous sample.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_edge
      assign rise[gi] = irq_in[gi] & ~irq_prev_reg[gi];
    end
  endgenerate

  assign cand   = pending_reg & enable_reg;
  assign id_hot = NUM_IRQ'(1) << id_reg;

  function automatic logic [ADDR_W-1:0] vec_addr(input logic [ID_W-1:0] id);
    return ADDR_W'(VEC_BASE) + ADDR_W'(id);
  endfunction

  // Fixed-priority encoder: the lowest candidate index wins.
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) win_id = ID_W'(i);
    end
  end

`ifdef IRQ_NEST_EN
  logic [NUM_IRQ-1:0] isv_low, isv_rest;
  logic [ID_W-1:0]    low_id, rest_id;

  // Lowest in-service index is the routine currently running; rest is what a done leaves.
  always_comb begin
    isv_low  = isv_reg & (~isv_reg + NUM_IRQ'(1));
    isv_rest = isv_reg & ~isv_low;
    low_id   = '0;
    rest_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (isv_reg[i])  low_id  = ID_W'(i);
      if (isv_rest[i]) rest_id = ID_W'(i);
    end
  end
`endif

  // Handshake FSM next-state logic, plus pending, enable and in-service updates.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    dir_next   = dir_reg;
    id_next    = id_reg;
    pend_clr   = '0;
    isv_set    = '0;
    isv_clr    = '0;
    case (state_reg)
      S_IDLE: begin
        if (|cand) begin
          id_next    = win_id;
          dir_next   = vec_addr(win_id);
          req_next   = 1'b1;
          state_next = S_REQ;
        end else begin
          dir_next = '0;
        end
      end
      S_REQ: begin
        if (ack) begin
          pend_clr   = id_hot;
          isv_set    = id_hot;
          req_next   = 1'b0;
          state_next = S_SERVICE;
        end
`ifdef IRQ_NEST_EN
        if (done) isv_clr = isv_low;
`endif
      end
      S_SERVICE: begin
`ifdef IRQ_NEST_EN
        if (done) isv_clr = isv_low;
        if ((|cand) && (win_id < low_id)) begin
          id_next    = win_id;
          dir_next   = vec_addr(win_id);
          req_next   = 1'b1;
          state_next = S_REQ;
        end else if (done) begin
          if (isv_rest == '0) begin
            state_next = S_IDLE;
          end else begin
            id_next  = rest_id;
            dir_next = vec_addr(rest_id);
          end
        end
`else
        if (done) begin
          isv_clr    = id_hot;
          state_next = S_IDLE;
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
    // A new event on the same edge as its clear wins.
    pending_next = (pending_reg & ~pend_clr) | rise;
    isv_next     = (isv_reg & ~isv_clr) | isv_set;
    enable_next  = en_we ? en_wdata : enable_reg;
  end

  // State and output registers; reset aborts any handshake immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      irq_prev_reg <= '0;
      pending_reg  <= '0;
      enable_reg   <= '1;
      isv_reg      <= '0;
      req_reg      <= 1'b0;
      dir_reg      <= '0;
      id_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      irq_prev_reg <= irq_in;
      pending_reg  <= pending_next;
      enable_reg   <= enable_next;
      isv_reg      <= isv_next;
      req_reg      <= req_next;
      dir_reg      <= dir_next;
      id_reg       <= id_next;
    end
  end

  assign irq_req     = req_reg;
  assign dir_out     = dir_reg;
  assign irq_id      = id_reg;
  assign busy        = |isv_reg;
  assign pending_out = pending_reg;

endmodule
